// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and frames them as start/8 data LSB-first/[parity]/1-2 stop bits.
// Latency: start bit appears on io_out the cycle after the accept edge; frame = (10 + nstop [+1 parity]) * (div+1) clocks.
// Backpressure: io_in_ready is high only while enabled and idle or in the last clock of the final stop bit; otherwise the FIFO holds.
//
// Ports:
//   clock, reset       system clock, asynchronous active-high reset
//   io_en              transmit enable; gates new accepts only, a frame in flight always completes
//   io_in_valid/ready  dequeue handshake with the TX FIFO; io_in_bits is the byte offered
//   io_div             bit period minus one, in clocks (sampled at accept)
//   io_nstop           0 = one stop bit, 1 = two stop bits (sampled at accept)
//   io_out             registered serial line, idles high
//   io_busy            frame in progress
//   io_parity_en/odd   parity insertion controls, present only when UART_TX_PARITY_EN is defined
module uart_tx_serializer #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [7:0]       io_in_bits,
  input  logic [DIV_W-1:0] io_div,
  input  logic             io_nstop,
`ifdef UART_TX_PARITY_EN
  input  logic             io_parity_en,
  input  logic             io_parity_odd,
`endif
  output logic             io_out,
  output logic             io_busy
);

  localparam logic [DIV_W-1:0] PRESC_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             nstop_q, nstop_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
`endif

  logic bit_end;
  logic last_stop;
  logic accept;

  // A bit ends on the clock where the prescaler has counted down to zero.
  assign bit_end   = (presc_q == '0);
  // stop_cnt runs 0..nstop, so the final stop bit is the one where they match.
  assign last_stop = (state_q == S_STOP) && bit_end && (stop_cnt_q == nstop_q);

  // Combinational so the FIFO pops on the same edge that loads the next frame.
  assign io_in_ready = io_en && ((state_q == S_IDLE) || last_stop);
  assign accept      = io_in_valid && io_in_ready;

  assign io_out  = out_q;
  assign io_busy = busy_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    presc_d    = presc_q;
    nstop_d    = nstop_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    out_d      = out_q;
    busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif

    if (state_q != S_IDLE) begin
      presc_d = bit_end ? div_q : (presc_q - PRESC_ONE);
    end

    case (state_q)
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          out_d     = shift_q[0];
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? S_PARITY : S_STOP;
            out_d   = par_en_q ? par_bit_q : 1'b1;
`else
            state_d = S_STOP;
            out_d   = 1'b1;
`endif
            stop_cnt_d = 1'b0;
          end else begin
            // Line shows the next LSB while the register shifts it into place.
            shift_d   = {1'b0, shift_q[7:1]};
            out_d     = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          out_d      = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            out_d      = 1'b1;
            presc_d    = '0;
            stop_cnt_d = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase

    // Accept wins over the end-of-frame return to idle, giving contiguous frames.
    if (accept) begin
      state_d    = S_START;
      shift_d    = io_in_bits;
      div_d      = io_div;
      presc_d    = io_div;
      nstop_d    = io_nstop;
      bit_cnt_d  = 3'd0;
      stop_cnt_d = 1'b0;
      out_d      = 1'b0;
      busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_d   = io_parity_en;
      par_bit_d  = (^io_in_bits) ^ io_parity_odd;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      presc_q    <= '0;
      nstop_q    <= 1'b0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      out_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      presc_q    <= presc_d;
      nstop_q    <= nstop_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: FIFO model on the dequeue side, per-cycle trace capture.
// Expected line/busy/accept traces are built from the frame format (bit lists repeated div+1 times).
// Parity cases run only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_serializer;

  localparam int DIV_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_en;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [7:0]       io_in_bits;
  logic [DIV_W-1:0] io_div;
  logic             io_nstop;
  logic             io_out;
  logic             io_busy;
`ifdef UART_TX_PARITY_EN
  logic             io_parity_en;
  logic             io_parity_odd;
`endif

  always #5 clock = ~clock;

  uart_tx_serializer #(.DIV_W(DIV_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_en        (io_en),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_div       (io_div),
    .io_nstop     (io_nstop),
`ifdef UART_TX_PARITY_EN
    .io_parity_en (io_parity_en),
    .io_parity_odd(io_parity_odd),
`endif
    .io_out       (io_out),
    .io_busy      (io_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo_q[$];
  logic       out_tr[$];
  logic       busy_tr[$];
  int         acc_tr[$];
  int         cyc;
  logic       exp_out[$];
  logic       exp_busy[$];
  int         exp_acc[$];

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         nstop;
    int         exp_len;
    int         exp_low;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic drive_fifo();
    io_in_valid = (fifo_q.size() > 0);
    io_in_bits  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  // One clock: decide the handshake from settled inputs, take the edge, then record outputs.
  task automatic step();
    logic       acc;
    logic [7:0] popped;
    #1;
    acc = io_in_valid & io_in_ready & ~reset;
    @(posedge clock);
    #1;
    if (acc) begin
      popped = fifo_q.pop_front();
      acc_tr.push_back(cyc);
    end
    drive_fifo();
    out_tr.push_back(io_out);
    busy_tr.push_back(io_busy);
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_rest();
    while (cyc < exp_out.size()) step();
  endtask

  task automatic begin_scen();
    out_tr.delete();
    busy_tr.delete();
    acc_tr.delete();
    exp_out.delete();
    exp_busy.delete();
    exp_acc.delete();
    cyc = 0;
  endtask

  // Reference frame: start, 8 data LSB first, optional parity, 1 or 2 stops, each held div+1 clocks.
  task automatic model_frame(input logic [7:0] d, input int div, input bit nstop,
                             input bit pen, input bit podd);
    logic bits[$];
    exp_acc.push_back(exp_out.size());
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((^d) ^ podd);
    bits.push_back(1'b1);
    if (nstop) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c <= div; c++) begin
        exp_out.push_back(bits[i]);
        exp_busy.push_back(1'b1);
      end
    end
  endtask

  task automatic model_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_out.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  task automatic compare_traces(input string name);
    int bad_o;
    int bad_b;
    int n;
    bad_o = -1;
    bad_b = -1;
    for (int k = 0; k < exp_out.size(); k++) begin
      if (bad_o < 0 && out_tr[k] !== exp_out[k]) bad_o = k;
      if (bad_b < 0 && busy_tr[k] !== exp_busy[k]) bad_b = k;
    end
    n_checks++;
    if (bad_o >= 0) begin
      n_fail++;
      $display("FAIL %s line: cycle %0d got %b required %b", name, bad_o, out_tr[bad_o], exp_out[bad_o]);
    end
    n_checks++;
    if (bad_b >= 0) begin
      n_fail++;
      $display("FAIL %s busy: cycle %0d got %b required %b", name, bad_b, busy_tr[bad_b], exp_busy[bad_b]);
    end
    check({name, " accept count"}, acc_tr.size(), exp_acc.size());
    n = (acc_tr.size() < exp_acc.size()) ? acc_tr.size() : exp_acc.size();
    for (int i = 0; i < n; i++) check({name, " accept cycle"}, acc_tr[i], exp_acc[i]);
  endtask

  function automatic int count_busy();
    int s = 0;
    foreach (busy_tr[i]) if (busy_tr[i] === 1'b1) s++;
    return s;
  endfunction

  function automatic int count_low();
    int s = 0;
    foreach (out_tr[i]) if (out_tr[i] === 1'b0) s++;
    return s;
  endfunction

  initial begin
    logic [7:0] b;
    int         nb;
    int         dv;
    bit         ns;

    tbl[0] = '{data: 8'hA5, div: 3, nstop: 1'b0, exp_len: 40, exp_low: 20};
    tbl[1] = '{data: 8'h80, div: 1, nstop: 1'b1, exp_len: 22, exp_low: 16};
    tbl[2] = '{data: 8'h00, div: 0, nstop: 1'b0, exp_len: 10, exp_low: 9};
    tbl[3] = '{data: 8'hFF, div: 2, nstop: 1'b1, exp_len: 33, exp_low: 3};
    tbl[4] = '{data: 8'h3C, div: 4, nstop: 1'b0, exp_len: 50, exp_low: 25};

    reset    = 1'b1;
    io_en    = 1'b1;
    io_div   = '0;
    io_nstop = 1'b0;
`ifdef UART_TX_PARITY_EN
    io_parity_en  = 1'b0;
    io_parity_odd = 1'b0;
`endif
    drive_fifo();
    #3;
    check("reset io_out", io_out, 1'b1);
    check("reset io_busy", io_busy, 1'b0);
    check("reset ready en=1", io_in_ready, 1'b1);
    io_en = 1'b0;
    #1;
    check("reset ready en=0", io_in_ready, 1'b0);
    io_en = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single-byte frames from the vector table.
    for (int t = 0; t < 5; t++) begin
      begin_scen();
      io_div   = DIV_W'(tbl[t].div);
      io_nstop = tbl[t].nstop;
      fifo_q.push_back(tbl[t].data);
      drive_fifo();
      model_frame(tbl[t].data, tbl[t].div, tbl[t].nstop, 1'b0, 1'b0);
      model_idle(3);
      run_rest();
      compare_traces($sformatf("vec%0d", t));
      check($sformatf("vec%0d busy length", t), count_busy(), tbl[t].exp_len);
      check($sformatf("vec%0d low clocks", t), count_low(), tbl[t].exp_low);
    end

    // Two queued bytes at div=0: contiguous frames, second pop in the last stop clock.
    begin_scen();
    io_div   = '0;
    io_nstop = 1'b0;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    drive_fifo();
    model_frame(8'h00, 0, 1'b0, 1'b0, 1'b0);
    model_frame(8'hFF, 0, 1'b0, 1'b0, 1'b0);
    model_idle(2);
    run_rest();
    compare_traces("b2b");
    check("b2b second pop edge", (acc_tr.size() > 1) ? acc_tr[1] : -1, 10);

    // io_div changed mid-frame: current frame keeps its latched divisor.
    begin_scen();
    io_div = 16'd2;
    fifo_q.push_back(8'h6B);
    fifo_q.push_back(8'hC4);
    drive_fifo();
    model_frame(8'h6B, 2, 1'b0, 1'b0, 1'b0);
    model_frame(8'hC4, 9, 1'b0, 1'b0, 1'b0);
    model_idle(3);
    steps(10);
    io_div = 16'd9;
    run_rest();
    compare_traces("divchg");

    // io_en gating: nothing accepted while low, a frame in flight completes after it drops.
    begin_scen();
    io_en    = 1'b0;
    io_div   = 16'd1;
    fifo_q.push_back(8'h33);
    fifo_q.push_back(8'h44);
    drive_fifo();
    model_idle(4);
    model_frame(8'h33, 1, 1'b0, 1'b0, 1'b0);
    model_idle(6);
    model_frame(8'h44, 1, 1'b0, 1'b0, 1'b0);
    model_idle(2);
    steps(4);
    check("en low ready", io_in_ready, 1'b0);
    io_en = 1'b1;
    steps(3);
    io_en = 1'b0;
    steps(23);
    check("en low fifo held", fifo_q.size(), 1);
    io_en = 1'b1;
    run_rest();
    compare_traces("en");

    // Reset during data bit 4 of 0x0F; the next byte goes out right after release.
    begin_scen();
    io_div = 16'd1;
    fifo_q.push_back(8'h0F);
    drive_fifo();
    steps(11);
    check("pre-reset bit4 low", io_out, 1'b0);
    fifo_q.push_back(8'h5A);
    drive_fifo();
    reset = 1'b1;
    #1;
    check("async reset io_out", io_out, 1'b1);
    check("async reset io_busy", io_busy, 1'b0);
    @(posedge clock);
    #1;
    check("reset held fifo", fifo_q.size(), 1);
    reset = 1'b0;
    begin_scen();
    model_frame(8'h5A, 1, 1'b0, 1'b0, 1'b0);
    model_idle(2);
    run_rest();
    compare_traces("post-reset");

    // Random bursts against the frame model.
    for (int r = 0; r < 20; r++) begin
      begin_scen();
      nb = $urandom_range(1, 3);
      dv = $urandom_range(0, 3);
      ns = 1'($urandom_range(0, 1));
      io_div   = DIV_W'(dv);
      io_nstop = ns;
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom_range(0, 255));
        fifo_q.push_back(b);
        model_frame(b, dv, ns, 1'b0, 1'b0);
      end
      model_idle(2);
      drive_fifo();
      run_rest();
      compare_traces($sformatf("rand%0d", r));
    end

`ifdef UART_TX_PARITY_EN
    for (int p = 0; p < 2; p++) begin
      begin_scen();
      io_div        = '0;
      io_nstop      = 1'b0;
      io_parity_en  = 1'b1;
      io_parity_odd = (p == 1);
      fifo_q.push_back(8'h07);
      drive_fifo();
      model_frame(8'h07, 0, 1'b0, 1'b1, (p == 1));
      model_idle(2);
      run_rest();
      compare_traces($sformatf("parity%0d", p));
      check($sformatf("parity%0d bit", p), out_tr[9], (p == 0) ? 1'b1 : 1'b0);
      check($sformatf("parity%0d length", p), count_busy(), 11);
    end
    io_parity_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
